// File: rtl/mdu.sv
// ---------------------------------------------------------------------------
// mdu -- multiply/divide unit holding the architectural HI/LO registers.
//
// MULT/MULTU/DIV/DIVU latch their operands when the start is accepted. The
// block then stays busy for a fixed, parameterised number of cycles and
// writes HI/LO on the final busy edge. MTHI/MTLO write HI/LO directly at the
// accepting edge. MFHI/MFLO are served combinationally through mdu_out.
//
// Parameters
//   MULT_CYCLES  busy cycles for MULT/MULTU (legal 1..31)
//   DIV_CYCLES   busy cycles for DIV/DIVU   (legal 1..31)
//
// Ports
//   clk      in   1   rising-edge clock
//   reset    in   1   asynchronous, active-low reset
//   mdu_op   in   4   0 NONE, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI,
//                     6 MTLO, 7 MFHI, 8 MFLO, 9-15 behave as NONE
//   start    in   1   qualifies mdu_op 1-6 this cycle
//   req      in   1   exception/interrupt cancel, inhibits start
//   rs_val   in  32   operand A
//   rt_val   in  32   operand B
//   busy     out  1   multiply/divide in progress
//   hi       out 32   architectural HI
//   lo       out 32   architectural LO
//   mdu_out  out 32   MFHI/MFLO read data, 0 for any other op
// ---------------------------------------------------------------------------
module mdu #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  mdu_op,
  input  logic        start,
  input  logic        req,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic [31:0] mdu_out
);

  localparam int DATA_W = 32;
  localparam int CNT_W  = 6;

  localparam logic [3:0] OP_NONE  = 4'd0;
  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MTHI  = 4'd5;
  localparam logic [3:0] OP_MTLO  = 4'd6;
  localparam logic [3:0] OP_MFHI  = 4'd7;
  localparam logic [3:0] OP_MFLO  = 4'd8;

  // Signed division done on magnitudes so that 0x80000000 / -1 needs no
  // special case: |0x80000000| is representable unsigned, the quotient
  // 0x80000000 negates back onto itself and the remainder is 0.
  // Returns {remainder, quotient}.
  function automatic logic [2*DATA_W-1:0] div_signed(
    input logic signed [DATA_W-1:0] a,
    input logic signed [DATA_W-1:0] b
  );
    logic [DATA_W-1:0] ua, ub, uq, ur, q, r;
    ua = a[DATA_W-1] ? (~a + 1'b1) : a;
    ub = b[DATA_W-1] ? (~b + 1'b1) : b;
    uq = ua / ub;
    ur = ua % ub;
    q  = (a[DATA_W-1] ^ b[DATA_W-1]) ? (~uq + 1'b1) : uq;
    r  = a[DATA_W-1] ? (~ur + 1'b1) : ur;
    return {r, q};
  endfunction

  // Returns {remainder, quotient}.
  function automatic logic [2*DATA_W-1:0] div_unsigned(
    input logic [DATA_W-1:0] a,
    input logic [DATA_W-1:0] b
  );
    return {a % b, a / b};
  endfunction

  logic                     accept;
  logic [CNT_W-1:0]         cnt;
  logic [3:0]               op_p0;
  logic signed [DATA_W-1:0] rs_p0;
  logic signed [DATA_W-1:0] rt_p0;

  logic signed [2*DATA_W-1:0] prod_s;
  logic [2*DATA_W-1:0]        prod_u;
  logic                       res_we;
  logic [DATA_W-1:0]          res_hi;
  logic [DATA_W-1:0]          res_lo;

  assign busy   = (cnt != '0);
  assign accept = start & ~req & ~busy;

  // ---- stage p0 -> completion: arithmetic on the latched operands ----
  assign prod_s = $signed({{DATA_W{rs_p0[DATA_W-1]}}, rs_p0})
                * $signed({{DATA_W{rt_p0[DATA_W-1]}}, rt_p0});
  assign prod_u = {{DATA_W{1'b0}}, rs_p0} * {{DATA_W{1'b0}}, rt_p0};

  always_comb begin
    res_we = 1'b0;
    res_hi = hi;
    res_lo = lo;
    case (op_p0)
      OP_MULT: begin
        res_we           = 1'b1;
        {res_hi, res_lo} = prod_s;
      end
      OP_MULTU: begin
        res_we           = 1'b1;
        {res_hi, res_lo} = prod_u;
      end
      OP_DIV: begin
        // A zero divisor still burns the full busy period but leaves HI/LO.
        if (rt_p0 != '0) begin
          res_we           = 1'b1;
          {res_hi, res_lo} = div_signed(rs_p0, rt_p0);
        end
      end
      OP_DIVU: begin
        if (rt_p0 != '0) begin
          res_we           = 1'b1;
          {res_hi, res_lo} = div_unsigned(rs_p0, rt_p0);
        end
      end
      default: ;
    endcase
  end

  // ---- stage p0: operand capture, countdown and HI/LO update ----
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt   <= '0;
      op_p0 <= OP_NONE;
      rs_p0 <= '0;
      rt_p0 <= '0;
      hi    <= '0;
      lo    <= '0;
    end else if (accept) begin
      // accept implies cnt == 0, so no countdown can be in flight here.
      case (mdu_op)
        OP_MULT, OP_MULTU: begin
          op_p0 <= mdu_op;
          rs_p0 <= rs_val;
          rt_p0 <= rt_val;
          cnt   <= CNT_W'(MULT_CYCLES);
        end
        OP_DIV, OP_DIVU: begin
          op_p0 <= mdu_op;
          rs_p0 <= rs_val;
          rt_p0 <= rt_val;
          cnt   <= CNT_W'(DIV_CYCLES);
        end
        OP_MTHI: hi <= rs_val;
        OP_MTLO: lo <= rs_val;
        default: ;
      endcase
    end else if (busy) begin
      cnt <= cnt - 1'b1;
      if (cnt == CNT_W'(1) && res_we) begin
        hi <= res_hi;
        lo <= res_lo;
      end
    end
  end

  // ---- read port: combinational view of the registered HI/LO ----
  always_comb begin
    mdu_out = '0;
    case (mdu_op)
      OP_MFHI: mdu_out = hi;
      OP_MFLO: mdu_out = lo;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mdu.sv
module tb_mdu;

  localparam int MC = 5;
  localparam int DC = 10;

  localparam logic [3:0] OP_NONE  = 4'd0;
  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MTHI  = 4'd5;
  localparam logic [3:0] OP_MTLO  = 4'd6;
  localparam logic [3:0] OP_MFHI  = 4'd7;
  localparam logic [3:0] OP_MFLO  = 4'd8;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  mdu_op;
  logic        start;
  logic        req;
  logic [31:0] rs_val;
  logic [31:0] rt_val;
  logic        busy;
  logic [31:0] hi;
  logic [31:0] lo;
  logic [31:0] mdu_out;

  mdu #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
    .clk     (clk),
    .reset   (reset),
    .mdu_op  (mdu_op),
    .start   (start),
    .req     (req),
    .rs_val  (rs_val),
    .rt_val  (rt_val),
    .busy    (busy),
    .hi      (hi),
    .lo      (lo),
    .mdu_out (mdu_out)
  );

  always #5 clk = ~clk;

  int          nvec = 0;
  int          nmis = 0;
  int          last_n = 0;
  logic [31:0] m_hi = '0;
  logic [31:0] m_lo = '0;

  typedef struct {
    logic [3:0]  op;
    logic [31:0] rs;
    logic [31:0] rt;
    logic [31:0] pre_hi;
    logic [31:0] pre_lo;
    logic [31:0] exp_hi;
    logic [31:0] exp_lo;
    int          cyc;
  } vec_t;

  vec_t tbl[9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nmis++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  // Issue one operation, wait out any busy period, and compare against a
  // plain-arithmetic model of the architectural HI/LO registers.
  task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic rq, input string tag);
    longint          sa, sb, q, r, p;
    longint unsigned ua, ub, pu, qu, ru;
    int              n_exp, n;
    logic [31:0]     new_hi, new_lo, rd_exp;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'h0, a};
    ub = {32'h0, b};
    n_exp  = 0;
    new_hi = m_hi;
    new_lo = m_lo;
    rd_exp = (op == OP_MFHI) ? m_hi : (op == OP_MFLO) ? m_lo : 32'h0;
    if (!rq) begin
      case (op)
        OP_MULT:  begin n_exp = MC; p = sa * sb; new_hi = p[63:32]; new_lo = p[31:0]; end
        OP_MULTU: begin n_exp = MC; pu = ua * ub; new_hi = pu[63:32]; new_lo = pu[31:0]; end
        OP_DIV: begin
          n_exp = DC;
          if (b != 0) begin q = sa / sb; r = sa % sb; new_hi = r[31:0]; new_lo = q[31:0]; end
        end
        OP_DIVU: begin
          n_exp = DC;
          if (b != 0) begin qu = ua / ub; ru = ua % ub; new_hi = ru[31:0]; new_lo = qu[31:0]; end
        end
        OP_MTHI: new_hi = a;
        OP_MTLO: new_lo = a;
        default: ;
      endcase
    end
    mdu_op = op; rs_val = a; rt_val = b; req = rq; start = 1'b1;
    #1 chk({tag, " rd"}, mdu_out, rd_exp);
    @(posedge clk); #1;
    start = 1'b0; req = 1'b0; mdu_op = OP_NONE;
    rs_val = $urandom; rt_val = $urandom;
    n = 0;
    while (busy && n < 64) begin
      mdu_op = n[0] ? OP_MFLO : OP_MFHI;
      #1 chk({tag, " old"}, mdu_out, n[0] ? m_lo : m_hi);
      n++;
      @(posedge clk); #1;
      rs_val = $urandom; rt_val = $urandom;
    end
    mdu_op = OP_NONE;
    last_n = n;
    chk({tag, " cycles"}, 32'(n), 32'(n_exp));
    chk({tag, " hi"}, hi, new_hi);
    chk({tag, " lo"}, lo, new_lo);
    m_hi = new_hi;
    m_lo = new_lo;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int          n;
    logic [3:0]  rop;
    logic [31:0] ra, rb;
    logic        rrq;

    tbl[0] = '{OP_MULT,  32'hFFFFFFFE, 32'h00000003, 32'h0,        32'h0,        32'hFFFFFFFF, 32'hFFFFFFFA, MC};
    tbl[1] = '{OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0,        32'h0,        32'hFFFFFFFE, 32'h00000001, MC};
    tbl[2] = '{OP_DIV,   32'hFFFFFFF9, 32'h00000002, 32'h0,        32'h0,        32'hFFFFFFFF, 32'hFFFFFFFD, DC};
    tbl[3] = '{OP_DIVU,  32'h12345678, 32'h00000000, 32'hA5A5A5A5, 32'h5A5A5A5A, 32'hA5A5A5A5, 32'h5A5A5A5A, DC};
    tbl[4] = '{OP_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h1,        32'h2,        32'h00000000, 32'h80000000, DC};
    tbl[5] = '{OP_DIVU,  32'd100,      32'd7,        32'h0,        32'h0,        32'd2,        32'd14,       DC};
    tbl[6] = '{OP_DIV,   32'd7,        32'hFFFFFFFE, 32'h0,        32'h0,        32'h00000001, 32'hFFFFFFFD, DC};
    tbl[7] = '{OP_MULT,  32'h80000000, 32'h80000000, 32'h0,        32'h0,        32'h40000000, 32'h00000000, MC};
    tbl[8] = '{OP_DIV,   32'hFFFFFF00, 32'h00000000, 32'h13579BDF, 32'h2468ACE0, 32'h13579BDF, 32'h2468ACE0, DC};

    reset = 1'b0; start = 1'b0; req = 1'b0; mdu_op = OP_NONE; rs_val = '0; rt_val = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset hi", hi, 32'h0);
    chk("reset lo", lo, 32'h0);
    chk("reset busy", 32'(busy), 32'h0);
    mdu_op = OP_MFHI;
    #1 chk("reset mdu_out", mdu_out, 32'h0);
    mdu_op = OP_NONE;
    reset = 1'b1;

    // First edge after release must accept.
    run_op(OP_MULT, 32'd6, 32'd7, 1'b0, "first");

    for (int i = 0; i < 9; i++) begin
      run_op(OP_MTHI, tbl[i].pre_hi, 32'h0, 1'b0, "pre_hi");
      run_op(OP_MTLO, tbl[i].pre_lo, 32'h0, 1'b0, "pre_lo");
      run_op(tbl[i].op, tbl[i].rs, tbl[i].rt, 1'b0, $sformatf("vec%0d", i));
      chk($sformatf("tbl%0d hi", i), hi, tbl[i].exp_hi);
      chk($sformatf("tbl%0d lo", i), lo, tbl[i].exp_lo);
      chk($sformatf("tbl%0d cycles", i), 32'(last_n), 32'(tbl[i].cyc));
    end

    // MTHI over a prior value, then MTLO cancelled by req.
    run_op(OP_MTHI, 32'h11111111, 32'h0, 1'b0, "mthi_a");
    run_op(OP_MTHI, 32'h12345678, 32'h0, 1'b0, "mthi_b");
    chk("mthi value", hi, 32'h12345678);
    run_op(OP_MTLO, 32'h22222222, 32'h0, 1'b0, "mtlo_a");
    run_op(OP_MTLO, 32'h0BADBEEF, 32'h0, 1'b1, "mtlo_req");
    chk("mtlo req ignored", lo, 32'h22222222);

    // Starts presented while busy must be ignored without touching the count.
    mdu_op = OP_MULT; rs_val = 32'd3; rt_val = 32'd4; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; mdu_op = OP_NONE;
    n = 0;
    while (busy && n < 64) begin
      if (n == 1) begin start = 1'b1; mdu_op = OP_DIV; rs_val = 32'd100; rt_val = 32'd5; end
      else if (n == 2) begin start = 1'b1; mdu_op = OP_MTHI; rs_val = 32'hDEADBEEF; end
      else begin start = 1'b0; mdu_op = OP_NONE; end
      n++;
      @(posedge clk); #1;
    end
    start = 1'b0; mdu_op = OP_NONE;
    chk("busy start cycles", 32'(n), 32'(MC));
    chk("busy start hi", hi, 32'h0);
    chk("busy start lo", lo, 32'd12);
    m_hi = 32'h0; m_lo = 32'd12;

    // Reset pulsed in busy cycle 3 of a MULT.
    run_op(OP_MTHI, 32'h55555555, 32'h0, 1'b0, "pre_rst_hi");
    run_op(OP_MTLO, 32'hAAAAAAAA, 32'h0, 1'b0, "pre_rst_lo");
    mdu_op = OP_MULT; rs_val = 32'd9; rt_val = 32'd9; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; mdu_op = OP_NONE;
    repeat (2) begin @(posedge clk); #1; end
    chk("pre reset busy", 32'(busy), 32'h1);
    reset = 1'b0;
    #1;
    chk("async rst hi", hi, 32'h0);
    chk("async rst lo", lo, 32'h0);
    chk("async rst busy", 32'(busy), 32'h0);
    mdu_op = OP_MFLO;
    #1 chk("rst mdu_out", mdu_out, 32'h0);
    mdu_op = OP_NONE;
    @(posedge clk); #1;
    chk("held rst busy", 32'(busy), 32'h0);
    reset = 1'b1;
    m_hi = '0; m_lo = '0;
    run_op(OP_MULT, 32'hFFFFFFFD, 32'd5, 1'b0, "post_rst");

    // Combinational read port.
    run_op(OP_MTLO, 32'hCAFEF00D, 32'h0, 1'b0, "mtlo_cafe");
    mdu_op = OP_MFLO;
    #1 chk("mflo same cycle", mdu_out, 32'hCAFEF00D);
    mdu_op = OP_NONE;
    #1 chk("none mdu_out", mdu_out, 32'h0);

    // Back-to-back: second start in the first non-busy cycle.
    run_op(OP_MULTU, 32'h00010000, 32'h00010000, 1'b0, "b2b_a");
    run_op(OP_DIVU, 32'hFFFFFFFF, 32'h00000010, 1'b0, "b2b_b");

    // Randomised ops against the model.
    for (int i = 0; i < 60; i++) begin
      rop = 4'($urandom_range(0, 15));
      ra  = $urandom;
      rb  = $urandom;
      if ((rop == OP_DIV || rop == OP_DIVU) && $urandom_range(0, 4) == 0) rb = 32'h0;
      if ($urandom_range(0, 3) == 0) rb = {28'h0, 4'($urandom_range(0, 15))};
      rrq = ($urandom_range(0, 4) == 0);
      run_op(rop, ra, rb, rrq, $sformatf("rnd%0d", i));
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule

// File: doc/mdu.md
MDU -- requirements
Module: mdu

Interface
Parameters (name, default, meaning):
REQ-001 The block SHALL have parameter MULT_CYCLES, default 5: busy cycles for MULT/MULTU.
REQ-002 The block SHALL have parameter DIV_CYCLES, default 10: busy cycles for DIV/DIVU.
Ports (name, direction, width, meaning):
REQ-003 The block SHALL have port clk, input, 1: the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port reset, input, 1: asynchronous, active-low reset.
REQ-005 The block SHALL have port mdu_op, input, 4: E-stage operation code, with encodings 0 NONE, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO, 7 MFHI, 8 MFLO, and 9-15 treated as NONE.
REQ-006 The block SHALL have port start, input, 1: qualifies mdu_op codes 1-6 for the current cycle.
REQ-007 The block SHALL have port req, input, 1: exception/interrupt cancel; when high, this cycle's start is inhibited.
REQ-008 The block SHALL have port rs_val, input, 32: operand A, forwarded GRF value.
REQ-009 The block SHALL have port rt_val, input, 32: operand B, forwarded GRF value.
REQ-010 The block SHALL have port busy, output, 1: a multiply or divide is in progress.
REQ-011 The block SHALL have port hi, output, 32: the architectural HI register.
REQ-012 The block SHALL have port lo, output, 32: the architectural LO register.
REQ-013 The block SHALL have port mdu_out, output, 32: the MFHI/MFLO read result for the E-stage result mux.

Function
REQ-014 An accepted start SHALL be start=1 AND req=0 AND busy=0, sampled at a rising edge; when any of these conditions fails, start SHALL be ignored.
REQ-015 On an accepted MULT/MULTU/DIV/DIVU, the block SHALL latch rs_val and rt_val into internal operand registers at that edge, and later changes to rs_val/rt_val SHALL have no effect.
REQ-016 On an accepted MULT/MULTU/DIV/DIVU, the block SHALL load an internal counter with MULT_CYCLES or DIV_CYCLES respectively.
REQ-017 busy SHALL equal (counter != 0), registered, so busy rises in the cycle after the accepted-start edge and stays high for exactly N cycles, where N is the loaded cycle count.
REQ-018 The counter SHALL decrement by 1 at each edge while it is nonzero.
REQ-019 At the edge where the counter goes from 1 to 0, the block SHALL write HI/LO from the latched operands; busy SHALL be low, with the new HI/LO visible, in the following cycle.
REQ-020 MULT SHALL compute the signed 32x32 product into 64 bits as {HI,LO}.
REQ-021 MULTU SHALL compute the unsigned 32x32 product into 64 bits as {HI,LO}.
REQ-022 DIV SHALL compute signed division with LO = quotient truncated toward zero and HI = remainder carrying the sign of the dividend.
REQ-023 DIVU SHALL compute unsigned division with LO = quotient and HI = remainder.
REQ-024 For DIV/DIVU with divisor 0, the block SHALL leave HI and LO unchanged at completion while still running the full DIV_CYCLES busy period.
REQ-025 DIV with 0x80000000 / 0xFFFFFFFF SHALL produce LO = 0x80000000 and HI = 0x00000000.
REQ-026 An accepted MTHI SHALL write HI = rs_val at that edge, with no busy period.
REQ-027 An accepted MTLO SHALL write LO = rs_val at that edge, with no busy period.
REQ-028 MTHI or MTLO presented while busy=1 or req=1 SHALL be ignored; the pipeline stalls it upstream.
REQ-029 mdu_out SHALL be combinational: hi when mdu_op=MFHI, lo when mdu_op=MFLO, otherwise 0.
REQ-030 mdu_out SHALL reflect the current registered HI/LO and SHALL NOT depend on start, req or busy.
REQ-031 While busy=1, an MFHI/MFLO read SHALL still return the old HI/LO, because the stall unit holds the reader in D.
REQ-032 Back-to-back operation: a start in the first cycle busy=0 after completion SHALL be accepted and SHALL use the freshly written HI/LO context.
REQ-033 Latency SHALL be parameter-exact for every legal value from 1 to 31.

Reset
REQ-034 When reset=0, asynchronously and regardless of clk, the block SHALL set hi=0, lo=0, counter=0, busy=0 and clear the operand registers.
REQ-035 A reset asserted mid-operation SHALL discard the in-flight result.
REQ-036 After reset deasserts, the block SHALL accept a start at the first rising edge.
REQ-037 mdu_out SHALL be 0 during reset unless mdu_op selects MFHI/MFLO, in which case it SHALL show 0.

Verification
REQ-038 MULT, rs=0xFFFFFFFE (-2), rt=0x00000003 -> busy high for 5 cycles; then hi=0xFFFFFFFF, lo=0xFFFFFFFA.
REQ-039 MULTU, rs=0xFFFFFFFF, rt=0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001, with rs/rt toggled during busy having no effect.
REQ-040 DIV rs=0xFFFFFFF9 (-7), rt=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF after 10 busy cycles; DIVU, rt=0 -> hi/lo unchanged and busy still 10 cycles.
REQ-041 With prior hi=0x11111111: MTHI rs=0x12345678 -> hi=0x12345678 next cycle; start+req=1 with MTLO -> lo unchanged; start during busy -> ignored and busy count unaffected.
REQ-042 MULT started, reset=0 pulsed in busy cycle 3 -> hi=lo=0 and busy=0 immediately; new MULT at the first edge after release completes correctly.
REQ-043 mdu_op=MFLO with lo=0xCAFEF00D -> mdu_out=0xCAFEF00D in the same cycle; mdu_op=NONE -> mdu_out=0.
